// File: rtl/calc_pkg.sv
// Shared definitions for the UART calculator output formatter.
// Holds the formatter state encoding, the ASCII constants it emits,
// the decimal digit count for a 32-bit product and a small helper that
// turns a BCD nibble into its ASCII character.
package calc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      EMIT,
      CR,
      LF
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam int         DEC_DIGITS = 10;

   // A BCD nibble always holds 0..9 here, so a plain offset from '0' is enough.
   function automatic logic [7:0] digit_char(input logic [3:0] nibble);
      return ASCII_ZERO + {4'h0, nibble};
   endfunction

endpackage

// File: rtl/mul_result_ascii_if.sv
// Byte stream from the formatter to the UART transmitter.
//   tx_data  : ASCII byte being offered
//   tx_valid : tx_data is valid and held until accepted
//   tx_ready : transmitter takes the byte in this cycle
// master = formatter side, slave = UART transmitter side.
interface mul_result_ascii_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : load bin, clear the BCD register, begin WIDTH iterations
//   bin      : unsigned binary value, sampled when start is high
//   bcd      : packed BCD digits, digit 0 in the low nibble
//   done     : high during the cycle whose closing edge performs the last
//              iteration, so bcd is final in the following cycle
module bin2bcd_seq
   import calc_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = DEC_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]          bin_reg;
   logic [CW-1:0]             count;
   logic [4*DIGITS-1:0]       adj;
   logic [4*DIGITS+WIDTH-1:0] shifted;

   // Add-3 correction: any digit of 5 or more would overflow past 9 after
   // the doubling shift, so it is pre-biased by 3 to carry correctly.
   always_comb begin
      adj = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
      end
   end

   assign shifted = {adj, bin_reg} << 1;
   assign done    = (count == CW'(1));

   // Iteration register: a start reloads everything, otherwise one shift of
   // {bcd, bin} per cycle while iterations remain.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_reg <= '0;
         bcd     <= '0;
         count   <= '0;
      end else if (start) begin
         bin_reg <= bin;
         bcd     <= '0;
         count   <= CW'(WIDTH);
      end else if (count != '0) begin
         bin_reg <= shifted[WIDTH-1:0];
         bcd     <= shifted[4*DIGITS+WIDTH-1:WIDTH];
         count   <= count - CW'(1);
      end
   end

endmodule

// File: rtl/mul_result_ascii.sv
// Formats a multiplier product as unsigned decimal ASCII for the UART TX.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   result   : product, valid in the done cycle
//   done     : single-cycle strobe from the multiplier
//   tx       : valid/ready byte stream to the UART transmitter (master)
//   busy     : high from capture until the final byte is accepted
//   overrun  : one-cycle pulse when done arrives while busy
// Leading zeros are suppressed (the last digit is always sent) and, when
// EOL_EN is set, CR LF follows the digits.
module mul_result_ascii
   import calc_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit EOL_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     result,
   input  logic                 done,
   mul_result_ascii_if.master   tx,
   output logic                 busy,
   output logic                 overrun
);

   localparam logic [3:0] DIGIT_LAST = 4'(DEC_DIGITS - 1);

   state_t                  state, state_next;
   logic [3:0]              idx, idx_next;
   logic                    lead, lead_next;
   logic                    start;
   logic                    conv_done;
   logic [4*DEC_DIGITS-1:0] bcd;
   logic [3:0]              nibble;
   logic [7:0]              data;
   logic                    valid;

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DEC_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (result),
      .bcd   (bcd),
      .done  (conv_done)
   );

   assign nibble      = bcd[{idx, 2'b00} +: 4];
   assign busy        = (state != IDLE);
   assign overrun     = done && busy && !rst;
   assign tx.tx_data  = data;
   assign tx.tx_valid = valid;

   // State, digit index and leading-zero flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         lead  <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         lead  <= lead_next;
      end
   end

   // Next-state and output decode. tx_valid/tx_data depend only on the
   // registered state, index, flag and BCD digits; tx_ready only steers
   // where the FSM goes next. Done outside IDLE never reaches the
   // converter, so a stream in progress cannot be disturbed.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      lead_next  = lead;
      start      = 1'b0;
      valid      = 1'b0;
      data       = 8'h00;
      unique case (state)
         IDLE: begin
            if (done) begin
               start      = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            if (conv_done) begin
               idx_next   = DIGIT_LAST;
               lead_next  = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (lead && (nibble == 4'd0) && (idx != 4'd0)) begin
               idx_next = idx - 4'd1;
            end else begin
               valid     = 1'b1;
               data      = digit_char(nibble);
               lead_next = 1'b0;
               if (tx.tx_ready) begin
                  if (idx != 4'd0) begin
                     idx_next = idx - 4'd1;
                  end else begin
                     state_next = EOL_EN ? CR : IDLE;
                  end
               end
            end
         end
         CR: begin
            valid = 1'b1;
            data  = ASCII_CR;
            if (tx.tx_ready) begin
               state_next = LF;
            end
         end
         LF: begin
            valid = 1'b1;
            data  = ASCII_LF;
            if (tx.tx_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mul_result_ascii.sv
// Directed self-checking bench for mul_result_ascii.
// Accepted bytes are logged with the cycle they were accepted in, and each
// scenario compares the log against a hand-written expected string.
module tb_mul_result_ascii;

   logic        clk;
   logic        rst;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        overrun;

   mul_result_ascii_if tx_bus ();

   mul_result_ascii #(
      .WIDTH  (32),
      .EOL_EN (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .result  (result),
      .done    (done),
      .tx      (tx_bus),
      .busy    (busy),
      .overrun (overrun)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         tEdge  = 0;
   logic [7:0] gotData[$];
   int         gotCyc[$];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to timestamp accepted bytes.
   always @(posedge clk) cyc <= cyc + 1;

   // Byte logger: a byte counts as transferred when valid and ready are both
   // high in a cycle; sampled mid-cycle so inputs and outputs are settled.
   always @(negedge clk) begin
      if (tx_bus.tx_valid && tx_bus.tx_ready) begin
         gotData.push_back(tx_bus.tx_data);
         gotCyc.push_back(cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pulse done for one cycle with the given product; tEdge records the
   // counter value right after the edge that samples it.
   task automatic applyStimulus(input logic [31:0] value);
      @(posedge clk);
      #1;
      done   = 1'b1;
      result = value;
      @(posedge clk);
      #1;
      done  = 1'b0;
      tEdge = cyc;
   endtask

   task automatic waitNotBusy(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic waitBytes(input string tag, input int count, input int budget);
      int n = 0;
      while (gotData.size() < count && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_bytes_seen"}, {31'd0, gotData.size() >= count}, 32'd1);
   endtask

   // firstOff is the spec-style cycle index (T+firstOff) of the first byte;
   // 0 skips that check. noGaps requires consecutive-cycle acceptance.
   task automatic checkStream(input string tag, input string exp,
                              input int firstOff, input bit noGaps);
      int n;
      checkOutput({tag, "_count"}, gotData.size(), exp.len());
      n = (gotData.size() < exp.len()) ? gotData.size() : exp.len();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, gotData[i]},
                     {24'd0, exp[i]});
      end
      if (firstOff > 0 && n > 0) begin
         checkOutput({tag, "_first_cycle"}, gotCyc[0] - tEdge + 1, firstOff);
      end
      if (noGaps) begin
         for (int i = 1; i < n; i++) begin
            checkOutput($sformatf("%s_gap%0d", tag, i), gotCyc[i] - gotCyc[i-1], 1);
         end
      end
   endtask

   initial begin
      rst              = 1'b1;
      done             = 1'b0;
      result           = 32'd0;
      tx_bus.tx_ready  = 1'b1;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tx_data", {24'd0, tx_bus.tx_data}, 32'h00);
      checkOutput("rst_tx_valid", {31'd0, tx_bus.tx_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;

      // Zero: nine skipped digits, a single '0', then CR LF.
      $display("[TB] result=0");
      gotData.delete(); gotCyc.delete();
      applyStimulus(32'd0);
      checkOutput("zero_busy_high", {31'd0, busy}, 32'd1);
      waitNotBusy("zero", 200);
      checkStream("zero", "0\r\n", 42, 1'b1);

      // 12345: five leading zeros skipped, then back-to-back bytes.
      $display("[TB] result=12345");
      gotData.delete(); gotCyc.delete();
      applyStimulus(32'd12345);
      waitNotBusy("d12345", 200);
      checkStream("d12345", "12345\r\n", 38, 1'b1);

      // All ones: ten digits, no skips.
      $display("[TB] result=FFFFFFFF");
      gotData.delete(); gotCyc.delete();
      applyStimulus(32'hFFFFFFFF);
      waitNotBusy("max", 200);
      checkStream("max", "4294967295\r\n", 33, 1'b1);

      // Back-pressure: '7' held stable for five stalled cycles.
      $display("[TB] result=7 with stall");
      gotData.delete(); gotCyc.delete();
      tx_bus.tx_ready = 1'b0;
      applyStimulus(32'd7);
      begin
         int n = 0;
         while (!tx_bus.tx_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput($sformatf("stall_valid%0d", i), {31'd0, tx_bus.tx_valid}, 32'd1);
         checkOutput($sformatf("stall_data%0d", i), {24'd0, tx_bus.tx_data}, 32'h37);
      end
      @(posedge clk);
      #1;
      tx_bus.tx_ready = 1'b1;
      waitNotBusy("stall", 200);
      checkStream("stall", "7\r\n", 0, 1'b1);

      // Overrun: a second done mid-stream is flagged and ignored.
      $display("[TB] overrun during 12345");
      gotData.delete(); gotCyc.delete();
      applyStimulus(32'd12345);
      waitBytes("ovr", 2, 200);
      @(posedge clk);
      #1;
      done   = 1'b1;
      result = 32'd99;
      @(negedge clk);
      checkOutput("ovr_pulse", {31'd0, overrun}, 32'd1);
      @(posedge clk);
      #1;
      done = 1'b0;
      @(negedge clk);
      checkOutput("ovr_after", {31'd0, overrun}, 32'd0);
      waitNotBusy("ovr", 200);
      checkStream("ovr", "12345\r\n", 38, 1'b1);

      // Reset mid-EMIT abandons the stream; the next value is clean.
      $display("[TB] reset during EMIT");
      gotData.delete(); gotCyc.delete();
      applyStimulus(32'd12345);
      waitBytes("rstmid", 2, 200);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstmid_valid", {31'd0, tx_bus.tx_valid}, 32'd0);
      checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
      checkOutput("rstmid_data", {24'd0, tx_bus.tx_data}, 32'h00);
      rst = 1'b0;
      gotData.delete(); gotCyc.delete();
      applyStimulus(32'd42);
      waitNotBusy("after_rst", 200);
      checkStream("after_rst", "42\r\n", 41, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
